zigzag_reorder_buf: RTL and testbench

Multi-bank reorder buffer for the JPEG encoder FDCT→quantiser path. It accepts 8x8 coefficient blocks in raster (row-major) order and emits them in zigzag, raster or transposed order. Up to NBANK blocks can be buffered, so a new block can be written while earlier ones are read. It generalises the fixed-width, single-buffer zigzag register file in fdct_zigzag with parametrised width, bank count, per-block order mode and valid/ready handshakes on both sides.

---
 rtl/zigzag_pkg.sv | 24 ++
 rtl/zigzag_addr_map.sv | 21 ++
 rtl/zigzag_reorder_buf.sv | 89 ++++++++
 tb/tb_zigzag_reorder_buf.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/zigzag_pkg.sv
// Shared constants for the 8x8 coefficient reorder path: block size, read-order
// modes and the JPEG zigzag scan table (sequence index -> raster address).
package zigzag_pkg;

  localparam int BLK_SIZE = 64;

  typedef enum logic [1:0] {
    ZZ_ORDER     = 2'd0,
    RASTER_ORDER = 2'd1,
    TRANS_ORDER  = 2'd2
  } order_e;

  localparam logic [5:0] ZZ [BLK_SIZE] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/zigzag_addr_map.sv
// Combinational map from (order mode, output sequence index) to raster address.
// Also used by the decoder-side inverse path.
module zigzag_addr_map
  import zigzag_pkg::*;
(
  input  logic [1:0] mode,
  input  logic [5:0] seq_idx,
  output logic [5:0] addr
);

  always_comb begin
    addr = ZZ[seq_idx];
    case (mode)
      RASTER_ORDER: addr = seq_idx;
      TRANS_ORDER:  addr = {seq_idx[2:0], seq_idx[5:3]};
      // mode 3 is reserved and falls back to zigzag
      default:      addr = ZZ[seq_idx];
    endcase
  end

endmodule

// File: rtl/zigzag_reorder_buf.sv
// NBANK-deep ring of 64-entry coefficient banks: raster-order writes, per-block
// zigzag/raster/transposed reads, valid/ready on both sides.
module zigzag_reorder_buf
  import zigzag_pkg::*;
#(
  parameter int DW    = 12,
  parameter int NBANK = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [1:0]    in_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [5:0]    out_idx,
  output logic          out_last,
  output logic          full,
  output logic          empty
);

  localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1;

  logic [DW-1:0]         mem [NBANK][BLK_SIZE];
  logic [NBANK-1:0]      complete, complete_nxt;
  logic [NBANK-1:0][1:0] tag;
  logic [BW-1:0]         wr_bank, rd_bank;
  logic [5:0]            wr_cnt, rd_cnt, rd_addr;
  logic                  wr_fire, rd_fire;

  function automatic logic [BW-1:0] next_bank(input logic [BW-1:0] b);
    return (b == BW'(NBANK - 1)) ? '0 : b + 1'b1;
  endfunction

  // Handshakes depend only on registered flags, so no input-to-output comb path.
  assign in_ready  = !complete[wr_bank];
  assign out_valid = complete[rd_bank];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;

  zigzag_addr_map u_addr_map (
    .mode    (tag[rd_bank]),
    .seq_idx (rd_cnt),
    .addr    (rd_addr)
  );

  assign out_data = mem[rd_bank][rd_addr];
  assign out_idx  = rd_cnt;
  assign out_last = out_valid && (rd_cnt == 6'd63);
  assign full     = &complete;
  assign empty    = ~|complete;

  // Write and read banks differ whenever both fire, so set and clear never collide.
  always_comb begin
    complete_nxt = complete;
    if (wr_fire && wr_cnt == 6'd63) complete_nxt[wr_bank] = 1'b1;
    if (rd_fire && rd_cnt == 6'd63) complete_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank  <= '0;
      rd_bank  <= '0;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      complete <= '0;
      tag      <= '0;
    end else begin
      if (wr_fire) begin
        wr_cnt <= wr_cnt + 6'd1;
        if (wr_cnt == 6'd0)  tag[wr_bank] <= in_mode;
        if (wr_cnt == 6'd63) wr_bank      <= next_bank(wr_bank);
      end
      if (rd_fire) begin
        rd_cnt <= rd_cnt + 6'd1;
        if (rd_cnt == 6'd63) rd_bank <= next_bank(rd_bank);
      end
      complete <= complete_nxt;
    end
  end

  // Coefficient storage carries no reset; stale data is masked by the flags.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_bank][wr_cnt] <= in_data;
  end

endmodule

// File: tb/tb_zigzag_reorder_buf.sv
// Directed + randomized bench for zigzag_reorder_buf against a block-level
// queue model (orders derived by walking anti-diagonals / columns).
module tb_zigzag_reorder_buf;

  localparam int DW    = 12;
  localparam int NBANK = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready, out_last, full, empty;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    in_mode;
  logic [5:0]    out_idx;

  zigzag_reorder_buf #(.DW(DW), .NBANK(NBANK)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] obs_log[$];
  logic [DW-1:0] blk [64];
  int            zz_ord [64];
  int            pending, wr_beat, rd_seq;
  logic [1:0]    cur_mode;
  logic          last_wf, last_rf, prev_stall;
  logic [DW-1:0] prev_data;
  logic [5:0]    prev_idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // zigzag scan: anti-diagonal s=r+c; odd diagonals run down-left, even up-right
  function automatic void build_zz();
    int n = 0;
    for (int s = 0; s < 15; s++) begin
      int lo, hi;
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 1) begin
        for (int r = lo; r <= hi; r++) begin zz_ord[n] = r * 8 + (s - r); n++; end
      end else begin
        for (int r = hi; r >= lo; r--) begin zz_ord[n] = r * 8 + (s - r); n++; end
      end
    end
  endfunction

  function automatic void push_block();
    for (int k = 0; k < 64; k++) begin
      case (cur_mode)
        2'd1:    exp_q.push_back(blk[k]);
        2'd2:    exp_q.push_back(blk[(k % 8) * 8 + k / 8]);  // column-major walk
        default: exp_q.push_back(blk[zz_ord[k]]);
      endcase
    end
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    pending = 0; wr_beat = 0; rd_seq = 0; prev_stall = 1'b0;
  endfunction

  // One clock: drive, check every output against the model, update, advance.
  task automatic cycle(input logic iv, input logic [DW-1:0] d, input logic [1:0] m, input logic ordy);
    logic exp_v;
    in_valid = iv; in_data = d; in_mode = m; out_ready = ordy;
    #1;
    exp_v = (pending > 0);
    chk("in_ready", in_ready, pending < NBANK);
    chk("out_valid", out_valid, exp_v);
    chk("full", full, pending == NBANK);
    chk("empty", empty, pending == 0);
    chk("out_idx", out_idx, rd_seq);
    chk("out_last", out_last, exp_v && rd_seq == 63);
    if (exp_v && exp_q.size() > 0) chk("out_data", out_data, exp_q[0]);
    if (prev_stall) begin
      chk("stall_data", out_data, prev_data);
      chk("stall_idx", out_idx, prev_idx);
    end
    last_wf = in_valid && in_ready;
    last_rf = out_valid && out_ready;
    if (last_wf) begin
      if (wr_beat == 0) cur_mode = in_mode;
      blk[wr_beat] = in_data;
      wr_beat++;
      if (wr_beat == 64) begin push_block(); pending++; wr_beat = 0; end
    end
    if (last_rf) begin
      obs_log.push_back(out_data);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      rd_seq++;
      if (rd_seq == 64) begin rd_seq = 0; pending--; end
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_idx   = out_idx;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_mode = 2'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  // mode used on the first beat; later beats carry random mode when rnd is set
  task automatic write_block(input logic [1:0] mode, input bit rnd, input logic ordy, input bit stall);
    for (int k = 0; k < 64; k++) begin
      logic [DW-1:0] d;
      logic [1:0]    m;
      int            tries;
      d = rnd ? DW'($urandom) : DW'(k);
      m = (k == 0 || !rnd) ? mode : 2'($urandom);
      tries = 0;
      do begin
        cycle(stall ? 1'($urandom) : 1'b1, d, m, stall ? 1'($urandom) : ordy);
        tries++;
      end while (!last_wf && tries < 300);
      if (!last_wf) begin
        chk("write_timeout", 32'd0, 32'd1);
        return;
      end
    end
  endtask

  task automatic drain(input bit rnd_ready, input int bound);
    int n = 0;
    while (exp_q.size() > 0 && n < bound) begin
      cycle(1'b0, '0, 2'd0, rnd_ready ? 1'($urandom) : 1'b1);
      n++;
    end
    chk("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int zz10 [10];
    zz10 = '{0, 1, 8, 16, 9, 2, 3, 10, 17, 24};
    build_zz();
    model_clear();

    // reset state
    do_reset();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);

    // zigzag block of ramp data; valid must appear right after the 64th accept
    obs_log.delete();
    write_block(2'd0, 1'b0, 1'b1, 1'b0);
    chk("latency_valid", out_valid, 1);
    chk("latency_data", out_data, 0);
    drain(1'b0, 100);
    chk("zz_count", obs_log.size(), 64);
    for (int i = 0; i < 10; i++) chk("zz_seq", obs_log[i], zz10[i]);
    chk("zz_tail", obs_log[63], 63);

    // raster then transposed
    obs_log.delete();
    write_block(2'd1, 1'b0, 1'b1, 1'b0);
    write_block(2'd2, 1'b0, 1'b1, 1'b0);
    drain(1'b0, 200);
    chk("raster_5", obs_log[5], 5);
    chk("trans_1", obs_log[65], 8);
    chk("trans_8", obs_log[72], 1);
    chk("trans_63", obs_log[127], 63);

    // back-pressure fill, then release while writing a third block
    write_block(2'd0, 1'b1, 1'b0, 1'b0);
    write_block(2'd2, 1'b1, 1'b0, 1'b0);
    chk("bp_full", full, 1);
    chk("bp_in_ready", in_ready, 0);
    write_block(2'd1, 1'b1, 1'b1, 1'b0);
    drain(1'b0, 300);

    // concurrent streaming, alternating modes
    for (int b = 0; b < 4; b++) write_block((b % 2 == 1) ? 2'd2 : 2'd0, 1'b1, 1'b1, 1'b0);
    drain(1'b0, 200);

    // random stalls on both sides, random modes including reserved
    for (int b = 0; b < 3; b++) write_block(2'($urandom), 1'b1, 1'b0, 1'b1);
    drain(1'b1, 2000);

    // mid-block reset: bank A partly read, bank B 30 beats written
    write_block(2'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) cycle(1'b1, DW'($urandom), 2'd1, 1'b1);
    do_reset();
    chk("mrst_empty", empty, 1);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_out_idx", out_idx, 0);
    write_block(2'd0, 1'b1, 1'b1, 1'b0);
    drain(1'b0, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
